// File: rtl/range_coalescer.sv
// range_coalescer: merges ascending inclusive ranges into closed intervals and totals covered IDs.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   valid_in / ready_in   beat handshake; a beat is taken only while ready_in=1 (IDLE)
//   pairs_in              8 ranges per beat {first, second}, lane 0 lowest
//   lane_valid_in         per-lane valid mask
//   last_in               beat closes the run
//   range_valid_out       one-cycle pulse qualifying range_out
//   range_out             closed merged range
//   total_out             running count of covered IDs for the current run
//   done_out              one-cycle pulse, total_out is final
//   err_out               sticky, a valid lane had first > second
package range_coalescer_pkg;
   localparam int DATA_WIDTH = 32;
   typedef struct packed {
      logic [DATA_WIDTH-1:0] first;
      logic [DATA_WIDTH-1:0] second;
   } tuple_pair_t;
endpackage

module range_coalescer
   import range_coalescer_pkg::*;
#(
   parameter int TOTAL_WIDTH = 64,
   parameter int LANES       = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         valid_in,
   input  tuple_pair_t [LANES-1:0]      pairs_in,
   input  logic        [LANES-1:0]      lane_valid_in,
   input  logic                         last_in,
   output logic                         ready_in,
   output logic                         range_valid_out,
   output tuple_pair_t                  range_out,
   output logic        [TOTAL_WIDTH-1:0] total_out,
   output logic                         done_out,
   output logic                         err_out
);
   localparam int LW = $clog2(LANES);
   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
   state_t                    state_q, state_d;
   tuple_pair_t [LANES-1:0]   beat_q, beat_d;
   logic        [LANES-1:0]   lv_q, lv_d;
   logic                      last_q, last_d;
   logic        [LW-1:0]      lane_q, lane_d;
   logic                      held_q, held_d;
   tuple_pair_t               cur_q, cur_d;
   logic                      range_valid_q, range_valid_d;
   tuple_pair_t               range_q, range_d;
   logic [TOTAL_WIDTH-1:0]    total_q, total_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   tuple_pair_t               lane_pair;
   logic [DATA_WIDTH:0]       cur_end1;
   logic [TOTAL_WIDTH-1:0]    span;

   assign lane_pair = beat_q[lane_q];
   // one extra bit so an all-ones end still compares as adjacent instead of wrapping to 0
   assign cur_end1  = {1'b0, cur_q.second} + 1'b1;
   assign span      = TOTAL_WIDTH'(cur_q.second) - TOTAL_WIDTH'(cur_q.first) + TOTAL_WIDTH'(1);

   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      lv_d          = lv_q;
      last_d        = last_q;
      lane_d        = lane_q;
      held_d        = held_q;
      cur_d         = cur_q;
      range_valid_d = 1'b0;
      range_d       = range_q;
      total_d       = total_q;
      done_d        = 1'b0;
      err_d         = err_q;
      unique case (state_q)
         IDLE: begin
            if (valid_in) begin
               beat_d  = pairs_in;
               lv_d    = lane_valid_in;
               last_d  = last_in;
               lane_d  = '0;
               state_d = SCAN;
               // no held range means this beat opens a new run
               if (!held_q) total_d = '0;
            end
         end
         SCAN: begin
            if (lv_q[lane_q]) begin
               if (lane_pair.first > lane_pair.second) begin
                  err_d = 1'b1;
               end else if (!held_q) begin
                  cur_d  = lane_pair;
                  held_d = 1'b1;
               end else if ({1'b0, lane_pair.first} <= cur_end1) begin
                  cur_d.second = (lane_pair.second > cur_q.second) ? lane_pair.second : cur_q.second;
               end else begin
                  range_valid_d = 1'b1;
                  range_d       = cur_q;
                  total_d       = total_q + span;
                  cur_d         = lane_pair;
               end
            end
            lane_d = lane_q + 1'b1;
            if (lane_q == LW'(LANES - 1)) state_d = last_q ? FLUSH : IDLE;
         end
         FLUSH: begin
            if (held_q) begin
               range_valid_d = 1'b1;
               range_d       = cur_q;
               total_d       = total_q + span;
            end
            held_d  = 1'b0;
            state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         beat_q        <= '0;
         lv_q          <= '0;
         last_q        <= 1'b0;
         lane_q        <= '0;
         held_q        <= 1'b0;
         cur_q         <= '0;
         range_valid_q <= 1'b0;
         range_q       <= '0;
         total_q       <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         lv_q          <= lv_d;
         last_q        <= last_d;
         lane_q        <= lane_d;
         held_q        <= held_d;
         cur_q         <= cur_d;
         range_valid_q <= range_valid_d;
         range_q       <= range_d;
         total_q       <= total_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   assign ready_in        = (state_q == IDLE);
   assign range_valid_out = range_valid_q;
   assign range_out       = range_q;
   assign total_out       = total_q;
   assign done_out        = done_q;
   assign err_out         = err_q;
endmodule

// File: tb/tb_range_coalescer.sv
// tb_range_coalescer: randomized and directed runs checked against an interval-merge model.
module tb_range_coalescer;
   import range_coalescer_pkg::*;

   typedef struct {
      tuple_pair_t [7:0] p;
      logic        [7:0] lv;
   } beat_t;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              valid_in = 1'b0;
   tuple_pair_t [7:0] pairs_in = '0;
   logic        [7:0] lane_valid_in = '0;
   logic              last_in = 1'b0;
   logic              ready_in;
   logic              range_valid_out;
   tuple_pair_t       range_out;
   logic       [63:0] total_out;
   logic              done_out;
   logic              err_out;

   int          passed = 0;
   int          checks = 0;
   int          cyc = 0;
   int          last_emit = 0;
   beat_t       stim[$];
   tuple_pair_t got[$];
   tuple_pair_t exp_q[$];
   logic [63:0] exp_total;
   logic        exp_err = 1'b0;

   range_coalescer #(.TOTAL_WIDTH(64), .LANES(8)) dut (
      .clock          (clock),
      .reset          (reset),
      .valid_in       (valid_in),
      .pairs_in       (pairs_in),
      .lane_valid_in  (lane_valid_in),
      .last_in        (last_in),
      .ready_in       (ready_in),
      .range_valid_out(range_valid_out),
      .range_out      (range_out),
      .total_out      (total_out),
      .done_out       (done_out),
      .err_out        (err_out)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      cyc++;
      if (range_valid_out) begin
         got.push_back(range_out);
         last_emit = cyc;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
      checks++;
      if (obs === req) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, req);
   endtask

   function automatic tuple_pair_t tp(input logic [31:0] f, input logic [31:0] s);
      return {f, s};
   endfunction

   // reference: concatenate all well-formed valid lanes of the run and fold them into disjoint intervals
   task automatic build_model();
      tuple_pair_t r, t;
      exp_q.delete();
      exp_total = 0;
      foreach (stim[b])
         for (int l = 0; l < 8; l++)
            if (stim[b].lv[l]) begin
               r = stim[b].p[l];
               if (r.first > r.second) exp_err = 1'b1;
               else if (exp_q.size() == 0 || 64'(r.first) > 64'(exp_q[exp_q.size()-1].second) + 64'd1)
                  exp_q.push_back(r);
               else begin
                  t = exp_q[exp_q.size()-1];
                  if (r.second > t.second) t.second = r.second;
                  exp_q[exp_q.size()-1] = t;
               end
            end
      foreach (exp_q[i]) exp_total += 64'(exp_q[i].second) - 64'(exp_q[i].first) + 64'd1;
   endtask

   task automatic drive_beat(input beat_t b, input logic last);
      int n = 0;
      @(negedge clock);
      while (!ready_in && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (!ready_in) check("ready_timeout", 64'(ready_in), 64'd1);
      pairs_in      = b.p;
      lane_valid_in = b.lv;
      last_in       = last;
      valid_in      = 1'b1;
      @(posedge clock);
      #1 valid_in = 1'b0;
   endtask

   // junk with valid_in high while busy must never be latched
   task automatic send_beat(input beat_t b, input logic last, input logic first);
      int cnt = 0;
      drive_beat(b, last);
      for (int k = 0; k < 30; k++) begin
         @(negedge clock);
         if (ready_in) break;
         if (first && cnt == 0) check("total_clear", total_out, 64'd0);
         cnt++;
         valid_in = 1'($urandom % 2);
         for (int l = 0; l < 8; l++) pairs_in[l] = tp($urandom, $urandom);
         lane_valid_in = 8'($urandom);
      end
      valid_in = 1'b0;
      #1;
      check("busy_cycles", 64'(cnt), last ? 64'd10 : 64'd8);
      check("done_pulse", 64'(done_out), 64'(last));
      if (last && exp_q.size() > 0) check("done_after_emit", 64'(cyc - last_emit), 64'd1);
   endtask

   task automatic run_case(input string name);
      got.delete();
      build_model();
      foreach (stim[i]) send_beat(stim[i], i == stim.size() - 1, i == 0);
      check({name, "_total"}, total_out, exp_total);
      check({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) if (i < got.size()) check({name, "_range"}, got[i], exp_q[i]);
      check({name, "_err"}, 64'(err_out), 64'(exp_err));
      @(negedge clock);
      #1;
      check({name, "_done_low"}, 64'(done_out), 64'd0);
      check({name, "_total_hold"}, total_out, exp_total);
   endtask

   function automatic beat_t empty_beat();
      beat_t b;
      for (int l = 0; l < 8; l++) b.p[l] = tp($urandom, $urandom);
      b.lv = '0;
      return b;
   endfunction

   task automatic gen_random();
      beat_t       b;
      logic [31:0] base, f, s;
      int          nb;
      stim.delete();
      nb   = $urandom_range(1, 3);
      base = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) begin
         b = empty_beat();
         for (int l = 0; l < 8; l++) begin
            f = base + $urandom_range(0, 4);
            s = f + $urandom_range(0, 5);
            if ($urandom_range(0, 9) == 0) s = f - 1;
            if ($urandom_range(0, 3) != 0) begin
               b.lv[l] = 1'b1;
               b.p[l]  = tp(f, s);
               base    = f;
            end
         end
         stim.push_back(b);
      end
   endtask

   initial begin
      beat_t b;
      repeat (2) @(negedge clock);
      #1;
      check("rst_ready", 64'(ready_in), 64'd1);
      check("rst_rv", 64'(range_valid_out), 64'd0);
      check("rst_range", range_out, 64'd0);
      check("rst_total", total_out, 64'd0);
      check("rst_done", 64'(done_out), 64'd0);
      check("rst_err", 64'(err_out), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      stim.delete();
      b = empty_beat();
      b.lv = 8'h0F;
      b.p[0] = tp(3, 5); b.p[1] = tp(10, 14); b.p[2] = tp(12, 18); b.p[3] = tp(16, 20);
      stim.push_back(b);
      run_case("one_beat");
      check("one_beat_plan", total_out, 64'd14);

      stim.delete();
      b = empty_beat();
      b.lv = 8'h07;
      b.p[0] = tp(1, 4); b.p[1] = tp(5, 8); b.p[2] = tp(10, 10);
      stim.push_back(b);
      run_case("adjacent");
      check("adjacent_plan", total_out, 64'd9);

      stim.delete();
      b = empty_beat();
      b.lv = 8'hFF;
      for (int l = 0; l < 8; l++) b.p[l] = tp(1, 32'(2 + l));
      stim.push_back(b);
      b = empty_beat();
      b.lv = 8'h01;
      b.p[0] = tp(10, 12);
      stim.push_back(b);
      run_case("carry");
      check("carry_plan", total_out, 64'd12);

      stim.delete();
      b = empty_beat();
      b.lv = 8'h03;
      b.p[0] = tp(0, 32'hFFFF_FFFF); b.p[1] = tp(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      stim.push_back(b);
      run_case("wrap");
      check("wrap_plan", total_out, 64'h1_0000_0000);

      stim.delete();
      b = empty_beat();
      b.lv = 8'h03;
      b.p[0] = tp(1, 2); b.p[1] = tp(7, 3);
      stim.push_back(b);
      run_case("malformed");
      check("malformed_plan", total_out, 64'd2);

      stim.delete();
      b = empty_beat();
      b.lv = 8'h01;
      b.p[0] = tp(1, 3);
      stim.push_back(b);
      stim.push_back(empty_beat());
      run_case("empty_last");

      for (int i = 0; i < 10; i++) begin
         gen_random();
         run_case("rand");
      end

      b = empty_beat();
      b.lv = 8'h07;
      b.p[0] = tp(1, 2); b.p[1] = tp(4, 5); b.p[2] = tp(7, 8);
      drive_beat(b, 1'b0);
      repeat (4) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_ready", 64'(ready_in), 64'd1);
      check("mid_rst_rv", 64'(range_valid_out), 64'd0);
      check("mid_rst_range", range_out, 64'd0);
      check("mid_rst_total", total_out, 64'd0);
      check("mid_rst_err", 64'(err_out), 64'd0);
      @(negedge clock);
      reset   = 1'b0;
      exp_err = 1'b0;

      stim.delete();
      b = empty_beat();
      b.lv = 8'h01;
      b.p[0] = tp(5, 6);
      stim.push_back(b);
      run_case("after_rst");
      check("after_rst_plan", total_out, 64'd2);

      for (int i = 0; i < 3; i++) begin
         gen_random();
         run_case("rand2");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/range_coalescer.md
Name: range_coalescer

Overview:
- Sits directly downstream of sorter_8 (asc=1) in the AOC day-5 pipeline.
- Accepts 8-lane beats of tuple_pair_t inclusive ranges (first = start, second = end), serialises them one lane per cycle, and merges overlapping or adjacent ranges into a running interval.
- Emits each closed merged range and accumulates the total count of covered IDs (sum of end-start+1) over a run.
- Input beats are ordered ascending by first across the whole run; the upstream merge logic owns that guarantee.

Parameters:
- TOTAL_WIDTH, 64, width of the covered-ID accumulator.
- LANES, 8, lanes per input beat; fixed at 8, present for readability only.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  beat present on pairs_in; accepted only when ready_in=1.
- pairs_in  in  tuple_pair_t[8]  sorted ranges, lane 0 lowest.
- lane_valid_in  in  8  per-lane valid mask; invalid lanes are ignored.
- last_in  in  1  beat is the final beat of the run.
- ready_in  out  1  block can accept a beat.
- range_valid_out  out  1  one-cycle pulse, range_out valid.
- range_out  out  tuple_pair_t  merged inclusive range.
- total_out  out  TOTAL_WIDTH  running covered-ID count for the current run.
- done_out  out  1  one-cycle pulse: run complete, total_out final.
- err_out  out  1  sticky: a valid lane had first > second.

Behaviour:
- Reset (async):
  - State=IDLE; ready_in=1; range_valid_out=0; range_out=0; total_out=0; done_out=0; err_out=0.
  - Running-range-held flag cleared.
- FSM states: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - ready_in=1.
  - valid_in=1 latches pairs_in, lane_valid_in and last_in, sets lane index=0, and moves to SCAN.
  - If no running range is held (first beat of a run), total_out clears to 0 in the same cycle.
- SCAN:
  - ready_in=0; one lane per cycle, always 8 cycles whether or not lanes are valid.
  - Invalid lane: no action.
  - Malformed lane (first > second): ignored; err_out set.
  - No running range held: load lane as cur.
  - lane.first <= cur.second+1 (compute cur.second+1 at DATA_WIDTH+1 bits, so all-ones never wraps): cur.second = max(cur.second, lane.second); no emit.
  - Otherwise:
    - Emit cur: range_valid_out=1, range_out=cur registered, so visible the cycle after the lane is processed.
    - total_out += cur.second-cur.first+1, computed at TOTAL_WIDTH.
    - Load lane as cur.
  - After lane 7: last beat goes to FLUSH; otherwise returns to IDLE with cur retained.
- FLUSH:
  - If a running range is held, emit it and add it to total_out, exactly as above.
  - Clear the held flag; go to DONE.
- DONE:
  - done_out=1 for one cycle with total_out final.
  - Return to IDLE.
  - total_out holds until the first beat of the next run is accepted.
- Latency and handshake:
  - Beat accept to IDLE re-entry is 9 cycles; the last beat adds 2 (FLUSH, DONE).
  - Steady throughput is one beat per 9 cycles.
  - No output backpressure; the consumer must take range_valid_out every cycle.
- Last beat with all lanes invalid: FLUSH emits the held range, or nothing if none is held; done_out still pulses.
- valid_in while ready_in=0: ignored and not latched; upstream holds the beat until ready_in.
- Reset mid-SCAN: all state and outputs return to reset values immediately; the partial run is discarded.
- Duplicate or identical ranges merge; a contained range (second < cur.second) leaves cur unchanged.

Test Plan:
- One last beat: (3,5),(10,14),(12,18),(16,20), lanes 4-7 invalid.
  - Required: emits (3,5) then (10,20); total_out=3+11=14; done_out one cycle after the FLUSH emit.
- Adjacency: (1,4),(5,8),(10,10), last.
  - Required: emits (1,8) and (10,10); total=9.
- Cross-beat carry: beat A (1,2)…(1,9) all 8 valid, not last; beat B (10,12), last.
  - Required: a single emit (1,12); total=12; ready_in low during each 8-cycle SCAN.
- Wrap boundary: (0,2^DATA_WIDTH-1) then (2^DATA_WIDTH-1,2^DATA_WIDTH-1), last.
  - Required: one range (0,max); total=2^DATA_WIDTH; no false split.
- Malformed lane (7,3) among valid (1,2), last.
  - Required: err_out=1 and stays 1; only (1,2) emitted; total=2.
- Reset asserted in SCAN cycle 4.
  - Required: outputs zero immediately, ready_in=1.
  - A following run (5,6) last produces total=2 with no residue.
